// File: rtl/hist_cdf_reader.sv
// hist_cdf_reader: reads histogram bins in order, streams the running CDF and flags a total mismatch.
module hist_cdf_reader #(
  parameter int NBINS  = 8,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [6:0]        dim,
  input  logic [DATA_W-1:0] hist_datain,
  output logic [ADDR_W-1:0] addr_hist,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_bin,
  output logic [DATA_W-1:0] out_cdf,
  output logic              busy,
  output logic              done,
  output logic              mismatch
);
  typedef enum logic [2:0] {IDLE, FETCH, READ, EMIT, DONE} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NBINS - 1);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] bin_q, bin_d, addr_q, addr_d, obin_q, obin_d;
  logic [DATA_W-1:0] cdf_q, cdf_d, total_q, total_d, ocdf_q, ocdf_d;
  logic valid_q, valid_d, done_q, done_d, mism_q, mism_d;
  logic [13:0] sq;
  assign sq = 14'(dim) * 14'(dim);
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    addr_d  = addr_q;
    obin_d  = obin_q;
    cdf_d   = cdf_q;
    total_d = total_q;
    ocdf_d  = ocdf_q;
    valid_d = valid_q;
    done_d  = done_q;
    mism_d  = mism_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = FETCH;
        cdf_d   = '0;
        bin_d   = '0;
        addr_d  = '0;
        mism_d  = 1'b0;
        total_d = DATA_W'(sq);
      end
      FETCH: state_d = READ;
      READ: begin
        cdf_d   = cdf_q + hist_datain;
        ocdf_d  = cdf_q + hist_datain;
        obin_d  = bin_q;
        valid_d = 1'b1;
        state_d = EMIT;
      end
      EMIT: if (out_ready) begin
        valid_d = 1'b0;
        if (bin_q == LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
          mism_d  = cdf_q != total_q;
        end else begin
          bin_d   = bin_q + 1'b1;
          addr_d  = bin_q + 1'b1;
          state_d = FETCH;
        end
      end
      DONE: begin
        done_d  = 1'b0;
        addr_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      addr_q  <= '0;
      obin_q  <= '0;
      cdf_q   <= '0;
      total_q <= '0;
      ocdf_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      mism_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      addr_q  <= addr_d;
      obin_q  <= obin_d;
      cdf_q   <= cdf_d;
      total_q <= total_d;
      ocdf_q  <= ocdf_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      mism_q  <= mism_d;
    end
  end
  assign addr_hist = addr_q;
  assign out_valid = valid_q;
  assign out_bin   = obin_q;
  assign out_cdf   = ocdf_q;
  assign busy      = state_q != IDLE;
  assign done      = done_q;
  assign mismatch  = mism_q;
endmodule

// File: tb/tb_hist_cdf_reader.sv
// tb_hist_cdf_reader: directed scenario tests for hist_cdf_reader against a small RAM model.
module tb_hist_cdf_reader;
  logic clk = 0, rst = 0, start = 0, out_ready = 1;
  logic [6:0] dim = 0;
  logic [31:0] hist_datain = 0;
  logic [5:0] addr_hist, out_bin;
  logic [31:0] out_cdf;
  logic out_valid, busy, done, mismatch;
  logic [31:0] mem [64];
  int errors = 0, checks = 0;

  hist_cdf_reader dut (
    .clk(clk), .rst(rst), .start(start), .dim(dim), .hist_datain(hist_datain),
    .addr_hist(addr_hist), .out_valid(out_valid), .out_ready(out_ready),
    .out_bin(out_bin), .out_cdf(out_cdf), .busy(busy), .done(done), .mismatch(mismatch)
  );

  always #5 clk = ~clk;
  always @(posedge clk) hist_datain <= mem[addr_hist];

  task automatic load(input int base, input int step);
    for (int i = 0; i < 64; i++) mem[i] = (i < 8) ? 32'(base + step * i) : 32'hdead_beef;
  endtask

  task automatic test_reset;
    rst = 0; start = 1; dim = 6;
    #22;
    checks++;
    if ({addr_hist, out_valid, out_bin, out_cdf, busy, done, mismatch} !== '0)
      begin errors++; $display("FAIL reset_outputs: addr=%0d valid=%b bin=%0d cdf=%0d busy=%b done=%b mm=%b, all required 0",
        addr_hist, out_valid, out_bin, out_cdf, busy, done, mismatch); end
    @(negedge clk); start = 0; rst = 1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_wins_start: busy=%b required 0", busy); end
  endtask

  task automatic test_stream(input logic [6:0] d, input logic exp_mm, input string nm);
    logic [31:0] exp_cdf [8];
    logic [31:0] run;
    int idx, dk;
    run = 0; idx = 0; dk = -1;
    for (int i = 0; i < 8; i++) begin run += mem[i]; exp_cdf[i] = run; end
    dim = d; out_ready = 1;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy: busy=%b required 1", nm, busy); end
    for (int k = 1; k <= 60; k++) begin
      if (out_valid) begin
        checks++;
        if (idx > 7) begin errors++; $display("FAIL %s_extra_output: bin=%0d beyond 8 outputs", nm, out_bin); end
        else if (out_bin !== 6'(idx) || out_cdf !== exp_cdf[idx])
          begin errors++; $display("FAIL %s_out%0d: got (%0d,%0d) required (%0d,%0d)", nm, idx, out_bin, out_cdf, idx, exp_cdf[idx]); end
        idx++;
      end
      if (done) begin
        dk = k;
        checks++;
        if (mismatch !== exp_mm) begin errors++; $display("FAIL %s_mismatch: got %b required %b", nm, mismatch, exp_mm); end
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (dk != 25) begin errors++; $display("FAIL %s_done_latency: got %0d required 25", nm, dk); end
    checks++;
    if (idx != 8) begin errors++; $display("FAIL %s_count: got %0d outputs required 8", nm, idx); end
  endtask

  task automatic test_mismatch_hold;
    @(negedge clk);
    checks++;
    if (mismatch !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || addr_hist !== 6'd0)
      begin errors++; $display("FAIL mm_hold: mm=%b done=%b busy=%b addr=%0d required 1,0,0,0", mismatch, done, busy, addr_hist); end
  endtask

  task automatic test_backpressure;
    int n, dk;
    logic seen;
    seen = 0; dk = -1; dim = 6; out_ready = 1;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (out_valid && out_bin == 6'd2) seen = 1; else @(negedge clk);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL bp_reach_bin2: out_bin never reached 2"); end
    out_ready = 0;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_bin !== 6'd2 || out_cdf !== 32'd6 || addr_hist !== 6'd2) n++;
    end
    checks++;
    if (n != 0) begin errors++; $display("FAIL bp_hold: %0d unstable cycles, last valid=%b bin=%0d cdf=%0d addr=%0d required 1,2,6,2",
      n, out_valid, out_bin, out_cdf, addr_hist); end
    out_ready = 1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || addr_hist !== 6'd3)
      begin errors++; $display("FAIL bp_release: valid=%b addr=%0d required 0,3", out_valid, addr_hist); end
    for (int k = 0; k < 40; k++) begin
      if (done) begin dk = k; break; end
      @(negedge clk);
    end
    checks++;
    if (dk < 0) begin errors++; $display("FAIL bp_done: done never seen"); end
  endtask

  task automatic test_start_ignored;
    int nd, nv;
    logic pulsed;
    nd = 0; nv = 0; pulsed = 0; dim = 6; out_ready = 1;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    for (int k = 1; k <= 50; k++) begin
      start = 0;
      if (out_valid) nv++;
      if (done) nd++;
      if (out_valid && out_bin == 6'd4 && !pulsed) begin start = 1; pulsed = 1; end
      @(negedge clk);
    end
    start = 0;
    checks++;
    if (nd != 1 || nv != 8) begin errors++; $display("FAIL start_ignored: done pulses=%0d outputs=%0d required 1 and 8", nd, nv); end
  endtask

  task automatic test_reset_mid;
    logic seen;
    seen = 0; dim = 6; out_ready = 1;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (out_valid && out_bin == 6'd3) seen = 1; else @(negedge clk);
    end
    out_ready = 0;
    #2 rst = 0;
    #1;
    checks++;
    if (!seen || {addr_hist, out_valid, out_bin, out_cdf, busy, done, mismatch} !== '0)
      begin errors++; $display("FAIL reset_mid: seen=%b addr=%0d valid=%b bin=%0d cdf=%0d busy=%b required all 0",
        seen, addr_hist, out_valid, out_bin, out_cdf, busy); end
    @(negedge clk); rst = 1; out_ready = 1;
    test_stream(6, 1'b0, "restart");
  endtask

  initial begin
    test_reset;
    load(1, 1);
    test_stream(6, 1'b0, "basic");
    test_stream(7, 1'b1, "dim7");
    test_mismatch_hold;
    test_stream(6, 1'b0, "b2b_a");
    test_stream(6, 1'b0, "b2b_b");
    test_backpressure;
    test_start_ignored;
    test_reset_mid;
    load(0, 0);
    test_stream(0, 1'b0, "zero");
    load(2016, 0);
    test_stream(127, 1'b1, "max");
    checks++;
    if (out_cdf !== 32'd16128) begin errors++; $display("FAIL max_final_cdf: got %0d required 16128", out_cdf); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hist_cdf_reader.md
Name: hist_cdf_reader

Overview:
- Consumer side of the histogram memory interface. The histogram controller fills bins 0..NBINS-1 of the 32-bit histogram RAM and pulses start; this block answers that pulse.
- On start it reads each bin in ascending order through the RAM read port and accumulates a running cumulative distribution (CDF).
- It streams one (bin, cdf) pair per bin over a valid/ready interface to the downstream equalization/display logic.
- It then pulses done and flags whether the final CDF equals the pixel count dim*dim.

Parameters:
- NBINS, 8, number of histogram bins read (addresses 0..NBINS-1).
- ADDR_W, 6, histogram RAM address width.
- DATA_W, 32, histogram RAM word width and CDF width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse from histogram controller: histogram RAM contents valid.
- dim  input  7  image dimension; expected total = dim*dim.
- hist_datain  input  DATA_W  histogram RAM read data, valid one cycle after address is sampled.
- addr_hist  output  ADDR_W  histogram RAM read address (registered).
- out_valid  output  1  (out_bin, out_cdf) valid.
- out_ready  input  1  downstream accepts when out_valid && out_ready.
- out_bin  output  ADDR_W  bin index of current output.
- out_cdf  output  DATA_W  sum of hist[0..out_bin].
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last bin is accepted.
- mismatch  output  1  registered with done; 1 when final cdf != dim*dim; holds until next start.

Behaviour:
- Reset (rst=0, any time, including mid-sequence):
  - State goes to IDLE immediately.
  - addr_hist=0, out_valid=0, out_bin=0, out_cdf=0, busy=0, done=0, mismatch=0.
  - Internal cdf and bin counter cleared.
- Internal registers: bin counter (ADDR_W), cdf accumulator (DATA_W), expected total = {zero-extend 14-bit dim*dim}, captured at start.
- States:
  - IDLE:
    - start=1 clears cdf and bin to 0, sets addr_hist=0, clears mismatch, captures dim*dim, goes to FETCH.
    - start=0 stays in IDLE.
  - FETCH: addr_hist holds bin; RAM samples the address at the closing edge; goes to READ.
  - READ:
    - hist_datain valid.
    - cdf <= cdf + hist_datain, modulo 2^DATA_W with no saturation; unreachable for dim<=127.
    - out_cdf <= same sum, out_bin <= bin, out_valid <= 1; goes to EMIT.
  - EMIT:
    - out_valid=1; out_bin and out_cdf held stable until the handshake.
    - On out_valid && out_ready: out_valid <= 0.
      - If bin==NBINS-1, go to DONE.
      - Otherwise bin <= bin+1, addr_hist <= bin+1, go to FETCH.
    - No handshake: stay in EMIT indefinitely.
  - DONE: done=1 for exactly one cycle; mismatch <= (cdf != total); addr_hist <= 0; goes to IDLE.
- Latency:
  - start sampled at edge E gives out_valid high after edge E+3 (IDLE, FETCH, READ).
  - With out_ready tied high, each bin takes 3 cycles and a full read takes 3*NBINS+1 cycles from start to done.
- start is ignored while busy=1; no queuing.
- start and rst asserted in the same cycle: reset wins.
- A back-to-back start in the cycle after done is accepted normally.
- out_ready asserted while out_valid=0 has no effect.
- dim=0: total=0; mismatch=1 unless all bins are 0.

Test Plan:
- Bins {1,2,3,4,5,6,7,8}, dim=6, out_ready=1:
  - outputs (0,1) (1,3) (2,6) (3,10) (4,15) (5,21) (6,28) (7,36).
  - done 25 cycles after start; mismatch=0.
- Same bins, dim=7: identical stream, mismatch=1 at done (36 != 49).
- Backpressure: out_ready low for 5 cycles on bin 2:
  - out_valid stays 1, out_bin=2 and out_cdf=6 stable.
  - addr_hist stays 2 until the handshake, then becomes 3.
- start pulsed while streaming bin 4: ignored; stream completes once; exactly one done pulse.
- rst low during EMIT of bin 3:
  - all outputs 0 immediately, busy=0.
  - Next start restarts from bin 0 with cdf=0.
- All bins 0, dim=0: all out_cdf=0, mismatch=0. All bins 2016 (8*2016=16128), dim=127: final out_cdf=16128, mismatch=1 (16129 expected).
